ddr_data_port: RTL and testbench

DDR-side burst adapter that sits directly downstream of the AP data cache. It takes the cache's level-sensitive read, store and jump-address requests and arbitrates between them. It drives a native burst interface on the DDR controller and returns beat data with the beat counter, valid and write-request timing that the cache consumes. One burst is in flight at a time; the current state is exported as `state_interface_module`.

---
 rtl/ddr_data_port_if.sv | 56 +++++
 rtl/ddr_data_port.sv | 145 ++++++++++++++
 tb/tb_ddr_data_port.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_data_port_if.sv
// rtl/ddr_data_port_if.sv - cache-side and DDR-controller-side signals of ddr_data_port
interface ddr_data_port_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int DDR_ADDR_WIDTH = 28
);
   // cache side
   logic                      DATA_read_req;
   logic                      DATA_store_req;
   logic                      JMP_ADDR_read_req;
   logic [DDR_ADDR_WIDTH-1:0] DATA_read_addr;
   logic [DDR_ADDR_WIDTH-1:0] DATA_write_addr;
   logic [DATA_WIDTH-1:0]     DATA_to_ddr;
   logic [DATA_WIDTH-1:0]     DATA_to_cache;
   logic [DDR_ADDR_WIDTH-1:0] JMP_ADDR_to_cache;
   logic [9:0]                rd_cnt_data;
   logic                      rd_burst_data_valid;
   logic                      wr_burst_data_req;
   logic [3:0]                state_interface_module;
   // DDR controller side
   logic                      rd_burst_req;
   logic                      wr_burst_req;
   logic [9:0]                rd_burst_len;
   logic [9:0]                wr_burst_len;
   logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
   logic [DDR_ADDR_WIDTH-1:0] wr_burst_addr;
   logic                      rd_burst_data_valid_i;
   logic                      wr_burst_data_req_i;
   logic                      rd_burst_finish;
   logic                      wr_burst_finish;
   logic [DATA_WIDTH-1:0]     rd_burst_data;
   logic [DATA_WIDTH-1:0]     wr_burst_data;

   // the adapter itself
   modport slave (
      input  DATA_read_req, DATA_store_req, JMP_ADDR_read_req,
      input  DATA_read_addr, DATA_write_addr, DATA_to_ddr,
      output DATA_to_cache, JMP_ADDR_to_cache, rd_cnt_data,
      output rd_burst_data_valid, wr_burst_data_req, state_interface_module,
      output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
      output rd_burst_addr, wr_burst_addr, wr_burst_data,
      input  rd_burst_data_valid_i, wr_burst_data_req_i,
      input  rd_burst_finish, wr_burst_finish, rd_burst_data
   );

   // the cache plus DDR controller around it
   modport master (
      output DATA_read_req, DATA_store_req, JMP_ADDR_read_req,
      output DATA_read_addr, DATA_write_addr, DATA_to_ddr,
      input  DATA_to_cache, JMP_ADDR_to_cache, rd_cnt_data,
      input  rd_burst_data_valid, wr_burst_data_req, state_interface_module,
      input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
      input  rd_burst_addr, wr_burst_addr, wr_burst_data,
      output rd_burst_data_valid_i, wr_burst_data_req_i,
      output rd_burst_finish, wr_burst_finish, rd_burst_data
   );
endinterface

// File: rtl/ddr_data_port.sv
// rtl/ddr_data_port.sv - single-burst DDR adapter between the AP data cache and the DDR controller
module ddr_data_port #(
   parameter int DATA_WIDTH     = 16,
   parameter int DDR_ADDR_WIDTH = 28,
   parameter int BURST_LEN      = 16
) (
   input  logic            clk,
   input  logic            rst,
   ddr_data_port_if.slave  bus
);
   localparam logic [3:0] IDLE                 = 4'd0;
   localparam logic [3:0] MEM_READ_DATA        = 4'd7;
   localparam logic [3:0] MEM_READ_JMP         = 4'd8;
   localparam logic [3:0] MEM_WRITE_DATA_STORE = 4'd9;
   localparam logic [3:0] RELEASE              = 4'd10;

   localparam logic [9:0] LEN_DATA = 10'(BURST_LEN);
   localparam logic [9:0] CNT_MAX  = 10'h3FF;

   logic [3:0]                state;
   logic [3:0]                state_nxt;
   logic                      rd_req_q;
   logic                      wr_req_q;
   logic [9:0]                rd_len_q;
   logic [9:0]                wr_len_q;
   logic [DDR_ADDR_WIDTH-1:0] rd_addr_q;
   logic [DDR_ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0]     data_q;
   logic [DDR_ADDR_WIDTH-1:0] jmp_q;
   logic [9:0]                cnt_q;
   logic                      valid_q;

   // Grants are only taken in IDLE; store beats jump, jump beats data read.
   logic grant_store;
   logic grant_jmp;
   logic grant_read;
   logic in_read;
   logic any_req;

   assign any_req     = bus.DATA_store_req | bus.JMP_ADDR_read_req | bus.DATA_read_req;
   assign grant_store = (state == IDLE) & bus.DATA_store_req;
   assign grant_jmp   = (state == IDLE) & ~bus.DATA_store_req & bus.JMP_ADDR_read_req;
   assign grant_read  = (state == IDLE) & ~bus.DATA_store_req & ~bus.JMP_ADDR_read_req
                        & bus.DATA_read_req;
   assign in_read     = (state == MEM_READ_DATA) | (state == MEM_READ_JMP);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state: one burst in flight; RELEASE waits for every request to drop
   // so a level request still held by the cache is not served twice.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if      (grant_store) state_nxt = MEM_WRITE_DATA_STORE;
            else if (grant_jmp)   state_nxt = MEM_READ_JMP;
            else if (grant_read)  state_nxt = MEM_READ_DATA;
         end
         MEM_READ_DATA,
         MEM_READ_JMP: begin
            if (bus.rd_burst_finish) state_nxt = RELEASE;
         end
         MEM_WRITE_DATA_STORE: begin
            if (bus.wr_burst_finish) state_nxt = RELEASE;
         end
         RELEASE: begin
            if (!any_req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Combinational outputs: write data request is a zero-latency pass-through in the store state only.
   always_comb begin
      bus.wr_burst_data_req      = bus.wr_burst_data_req_i & (state == MEM_WRITE_DATA_STORE);
      bus.wr_burst_data          = bus.DATA_to_ddr;
      bus.state_interface_module = state;
   end

   // Burst request, length and address towards the controller; request drops at the first beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_req_q  <= 1'b0;
         wr_req_q  <= 1'b0;
         rd_len_q  <= '0;
         wr_len_q  <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
      end else begin
         if (grant_store) begin
            wr_req_q  <= 1'b1;
            wr_len_q  <= LEN_DATA;
            wr_addr_q <= bus.DATA_write_addr;
         end else if (grant_jmp) begin
            rd_req_q  <= 1'b1;
            rd_len_q  <= 10'd1;
            rd_addr_q <= bus.DATA_read_addr;
         end else if (grant_read) begin
            rd_req_q  <= 1'b1;
            rd_len_q  <= LEN_DATA;
            rd_addr_q <= bus.DATA_read_addr;
         end
         if (in_read && (bus.rd_burst_data_valid_i || bus.rd_burst_finish))
            rd_req_q <= 1'b0;
         if ((state == MEM_WRITE_DATA_STORE) && (bus.wr_burst_data_req_i || bus.wr_burst_finish))
            wr_req_q <= 1'b0;
      end
   end

   // Read beats: register data, valid and a saturating beat counter the cache uses as its write index.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         jmp_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= in_read & bus.rd_burst_data_valid_i;
         if (grant_read) begin
            cnt_q <= 10'd1;
         end else if (grant_jmp) begin
            cnt_q <= 10'd0;
         end else if (in_read && bus.rd_burst_data_valid_i) begin
            data_q <= bus.rd_burst_data;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 10'd1;
            if (state == MEM_READ_JMP) jmp_q <= DDR_ADDR_WIDTH'(bus.rd_burst_data);
         end
      end
   end

   assign bus.rd_burst_req        = rd_req_q;
   assign bus.wr_burst_req        = wr_req_q;
   assign bus.rd_burst_len        = rd_len_q;
   assign bus.wr_burst_len        = wr_len_q;
   assign bus.rd_burst_addr       = rd_addr_q;
   assign bus.wr_burst_addr       = wr_addr_q;
   assign bus.DATA_to_cache       = data_q;
   assign bus.JMP_ADDR_to_cache   = jmp_q;
   assign bus.rd_cnt_data         = cnt_q;
   assign bus.rd_burst_data_valid = valid_q;
endmodule

// File: tb/tb_ddr_data_port.sv
// tb/tb_ddr_data_port.sv - self-checking bench for ddr_data_port
module tb_ddr_data_port;
   localparam int DW = 16;
   localparam int AW = 28;
   localparam int BL = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // reference model state
   logic [9:0]    cnt_exp = '0;
   logic [AW-1:0] jmp_exp = '0;

   always #5 clk = ~clk;

   ddr_data_port_if #(.DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW)) bus ();

   ddr_data_port #(.DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int            kind;      // 0 data read, 1 jump read, 2 store
      logic [AW-1:0] addr;
      logic [15:0]   base;
      bit            same_fin;
      int            hold;
      logic [3:0]    exp_state;
      logic [9:0]    exp_len;
      logic [9:0]    exp_preset;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.DATA_read_req         = 1'b0;
      bus.DATA_store_req        = 1'b0;
      bus.JMP_ADDR_read_req     = 1'b0;
      bus.rd_burst_data_valid_i = 1'b0;
      bus.wr_burst_data_req_i   = 1'b0;
      bus.rd_burst_finish       = 1'b0;
      bus.wr_burst_finish       = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_state"},  32'(bus.state_interface_module), 32'd0);
      chk({tag, "_rdreq"},  32'(bus.rd_burst_req), 32'd0);
      chk({tag, "_wrreq"},  32'(bus.wr_burst_req), 32'd0);
      chk({tag, "_valid"},  32'(bus.rd_burst_data_valid), 32'd0);
      chk({tag, "_cnt"},    32'(bus.rd_cnt_data), 32'd0);
      chk({tag, "_data"},   32'(bus.DATA_to_cache), 32'd0);
      chk({tag, "_jmp"},    32'(bus.JMP_ADDR_to_cache), 32'd0);
      chk({tag, "_rdaddr"}, 32'(bus.rd_burst_addr), 32'd0);
      chk({tag, "_wraddr"}, 32'(bus.wr_burst_addr), 32'd0);
      chk({tag, "_rdlen"},  32'(bus.rd_burst_len), 32'd0);
      chk({tag, "_wrlen"},  32'(bus.wr_burst_len), 32'd0);
      chk({tag, "_wdreq"},  32'(bus.wr_burst_data_req), 32'd0);
   endtask

   // One complete burst from request to return to IDLE, with the bench acting as cache and controller.
   task automatic run_burst(input int kind, input logic [AW-1:0] addr, input logic [15:0] base,
                            input bit rnd, input bit same_fin, input int hold,
                            input logic [3:0] es, input logic [9:0] el, input logic [9:0] ep);
      int          nbeats;
      int          gaps;
      logic [15:0] d;
      nbeats = (kind == 1) ? 1 : BL;
      bus.DATA_read_addr  = (kind == 2) ? ~addr : addr;
      bus.DATA_write_addr = (kind == 2) ? addr : ~addr;
      case (kind)
         0:       bus.DATA_read_req     = 1'b1;
         1:       bus.JMP_ADDR_read_req = 1'b1;
         default: bus.DATA_store_req    = 1'b1;
      endcase
      tick();
      chk("grant_state", 32'(bus.state_interface_module), 32'(es));
      if (kind < 2) begin
         chk("grant_rdreq", 32'(bus.rd_burst_req), 32'd1);
         chk("grant_rdaddr", 32'(bus.rd_burst_addr), 32'(addr));
         chk("grant_rdlen", 32'(bus.rd_burst_len), 32'(el));
         chk("grant_preset", 32'(bus.rd_cnt_data), 32'(ep));
      end else begin
         chk("grant_wrreq", 32'(bus.wr_burst_req), 32'd1);
         chk("grant_wraddr", 32'(bus.wr_burst_addr), 32'(addr));
         chk("grant_wrlen", 32'(bus.wr_burst_len), 32'(el));
      end
      for (int i = 0; i < nbeats; i++) begin
         gaps = rnd ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < gaps; g++) begin
            // requests and write handshakes outside their state must have no effect
            bus.DATA_store_req    = (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.JMP_ADDR_read_req = (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (kind < 2) begin
               bus.wr_burst_data_req_i = 1'b1;
               #1;
               chk("wdreq_gated", 32'(bus.wr_burst_data_req), 32'd0);
            end
            tick();
            bus.wr_burst_data_req_i = 1'b0;
            chk("gap_state", 32'(bus.state_interface_module), 32'(es));
            if (kind < 2) chk("gap_valid", 32'(bus.rd_burst_data_valid), 32'd0);
            if (i == 0 && kind < 2) chk("gap_rdreq", 32'(bus.rd_burst_req), 32'd1);
            if (i == 0 && kind == 2) chk("gap_wrreq", 32'(bus.wr_burst_req), 32'd1);
         end
         d = rnd ? 16'($urandom) : base + 16'(i);
         if (kind < 2) begin
            bus.rd_burst_data         = d;
            bus.rd_burst_data_valid_i = 1'b1;
            bus.rd_burst_finish       = same_fin && (i == nbeats - 1);
            tick();
            bus.rd_burst_data_valid_i = 1'b0;
            bus.rd_burst_finish       = 1'b0;
            chk("beat_valid", 32'(bus.rd_burst_data_valid), 32'd1);
            chk("beat_data", 32'(bus.DATA_to_cache), 32'(d));
            chk("beat_cnt", 32'(bus.rd_cnt_data), 32'(ep) + 32'(i) + 32'd1);
            chk("beat_rdreq", 32'(bus.rd_burst_req), 32'd0);
            if (kind == 1) begin
               jmp_exp = AW'(d);
               chk("beat_jmp", 32'(bus.JMP_ADDR_to_cache), 32'(jmp_exp));
            end
         end else begin
            bus.DATA_to_ddr         = d;
            bus.wr_burst_data_req_i = 1'b1;
            bus.wr_burst_finish     = same_fin && (i == nbeats - 1);
            #1;
            chk("store_wdreq", 32'(bus.wr_burst_data_req), 32'd1);
            chk("store_wdata", 32'(bus.wr_burst_data), 32'(d));
            tick();
            bus.wr_burst_data_req_i = 1'b0;
            bus.wr_burst_finish     = 1'b0;
            chk("store_wrreq", 32'(bus.wr_burst_req), 32'd0);
         end
      end
      if (kind < 2) cnt_exp = ep + 10'(nbeats);
      if (!same_fin) begin
         if (kind < 2) bus.rd_burst_finish = 1'b1;
         else          bus.wr_burst_finish = 1'b1;
         tick();
         bus.rd_burst_finish = 1'b0;
         bus.wr_burst_finish = 1'b0;
      end
      chk("fin_state", 32'(bus.state_interface_module), 32'd10);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("hold_state", 32'(bus.state_interface_module), 32'd10);
         chk("hold_rdreq", 32'(bus.rd_burst_req), 32'd0);
         chk("hold_wrreq", 32'(bus.wr_burst_req), 32'd0);
      end
      clear_inputs();
      tick();
      chk("idle_state", 32'(bus.state_interface_module), 32'd0);
      chk("idle_cnt", 32'(bus.rd_cnt_data), 32'(cnt_exp));
      chk("idle_jmp", 32'(bus.JMP_ADDR_to_cache), 32'(jmp_exp));
      chk("idle_valid", 32'(bus.rd_burst_data_valid), 32'd0);
   endtask

   initial begin
      clear_inputs();
      bus.DATA_read_addr  = '0;
      bus.DATA_write_addr = '0;
      bus.DATA_to_ddr     = '0;
      bus.rd_burst_data   = '0;

      vecs[0] = '{0, 28'h0000400, 16'hA000, 1'b0, 0, 4'd7, 10'd16, 10'd1};
      vecs[1] = '{1, 28'h0000777, 16'h1234, 1'b0, 0, 4'd8, 10'd1,  10'd0};
      vecs[2] = '{2, 28'h0000800, 16'h5500, 1'b0, 0, 4'd9, 10'd16, 10'd0};
      vecs[3] = '{0, 28'hFFFFFFF, 16'hFFF0, 1'b1, 3, 4'd7, 10'd16, 10'd1};
      vecs[4] = '{2, 28'h0ABCDEF, 16'h0F00, 1'b1, 2, 4'd9, 10'd16, 10'd0};
      vecs[5] = '{1, 28'h0000000, 16'hBEEF, 1'b1, 1, 4'd8, 10'd1,  10'd0};

      repeat (2) tick();
      check_reset_values("reset");
      rst = 1'b1;
      tick();
      chk("post_reset_state", 32'(bus.state_interface_module), 32'd0);

      for (int v = 0; v < 6; v++)
         run_burst(vecs[v].kind, vecs[v].addr, vecs[v].base, 1'b0, vecs[v].same_fin, vecs[v].hold,
                   vecs[v].exp_state, vecs[v].exp_len, vecs[v].exp_preset);
      chk("jmp_after_table", 32'(bus.JMP_ADDR_to_cache), 32'h000BEEF);

      // priority: all three in IDLE -> store; then jump over read; then read
      bus.DATA_store_req = 1'b1; bus.JMP_ADDR_read_req = 1'b1; bus.DATA_read_req = 1'b1;
      tick();
      chk("prio_store", 32'(bus.state_interface_module), 32'd9);
      chk("prio_store_rdreq", 32'(bus.rd_burst_req), 32'd0);
      bus.wr_burst_finish = 1'b1;
      tick();
      bus.wr_burst_finish = 1'b0;
      bus.DATA_store_req  = 1'b0;
      tick();
      chk("release_waits_all", 32'(bus.state_interface_module), 32'd10);
      bus.JMP_ADDR_read_req = 1'b0; bus.DATA_read_req = 1'b0;
      tick();
      chk("release_to_idle", 32'(bus.state_interface_module), 32'd0);
      bus.JMP_ADDR_read_req = 1'b1; bus.DATA_read_req = 1'b1;
      tick();
      chk("prio_jmp", 32'(bus.state_interface_module), 32'd8);
      chk("prio_jmp_len", 32'(bus.rd_burst_len), 32'd1);
      bus.rd_burst_finish = 1'b1;
      tick();
      bus.rd_burst_finish = 1'b0;
      clear_inputs();
      tick();
      bus.DATA_read_req = 1'b1;
      tick();
      chk("prio_read", 32'(bus.state_interface_module), 32'd7);
      chk("prio_read_len", 32'(bus.rd_burst_len), 32'd16);
      bus.rd_burst_finish = 1'b1;
      tick();
      clear_inputs();
      tick();
      cnt_exp = 10'd1;
      chk("prio_done", 32'(bus.state_interface_module), 32'd0);

      // asynchronous reset in the middle of a data read
      bus.DATA_read_addr = 28'h0000C00;
      bus.DATA_read_req  = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         bus.rd_burst_data = 16'hC000 + 16'(i);
         bus.rd_burst_data_valid_i = 1'b1;
         tick();
      end
      chk("pre_reset_cnt", 32'(bus.rd_cnt_data), 32'd6);
      #2;
      rst = 1'b0;
      #1;
      check_reset_values("midreset");
      clear_inputs();
      tick();
      rst = 1'b1;
      tick();
      cnt_exp = '0;
      jmp_exp = '0;
      run_burst(0, 28'h0000C00, 16'hD000, 1'b0, 1'b0, 0, 4'd7, 10'd16, 10'd1);

      // randomized bursts against the model
      for (int r = 0; r < 14; r++) begin
         int k;
         k = int'($urandom_range(0, 2));
         run_burst(k, AW'($urandom), 16'h0, 1'b1, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), (k == 0) ? 4'd7 : (k == 1) ? 4'd8 : 4'd9,
                   (k == 1) ? 10'd1 : 10'd16, (k == 0) ? 10'd1 : 10'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
